// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams host words into the datapath's
// unified memory, then releases the CPU from reset after a hold interval.
module program_loader #(
   parameter logic [15:0] START_ADDR  = 16'h0000,
   parameter int unsigned MAX_WORDS   = 1024,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [15:0] s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        cpu_nrst,
   output logic        done,
   output logic        err_overflow,
   output logic [15:0] word_count
);

   localparam int unsigned AW = 16;
   localparam int unsigned CW = 8;
   localparam logic [AW-1:0] MAX_CNT  = AW'(MAX_WORDS);
   localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_HOLD  = 3'd2,
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [AW-1:0]   ptr;
   logic [CW-1:0]   hold_cnt;
   logic            xfer_c;
   logic            restart_c;
   logic [AW-1:0]   count_inc_c;
   logic            s_ready_d;
   logic            cpu_nrst_d;
   logic            done_d;
   logic            err_d;

   // Handshake and restart qualifiers; s_ready is a flop so xfer is glitch-free
   always_comb begin
      xfer_c      = s_valid && s_ready;
      restart_c   = start && ((state == S_IDLE) || (state == S_RUN));
      count_inc_c = word_count + 16'd1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_LOAD;
         S_LOAD: begin
            if (xfer_c) begin
               if (s_last)                      next_state = S_HOLD;
               else if (count_inc_c == MAX_CNT) next_state = S_ERROR;
            end
         end
         S_HOLD:  if (hold_cnt == '0) next_state = S_RUN;
         S_RUN:   if (start) next_state = S_LOAD;
         S_ERROR: next_state = S_ERROR;
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the status outputs come straight off flops
   always_comb begin
      s_ready_d  = 1'b0;
      cpu_nrst_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_overflow;
      case (next_state)
         S_LOAD:  s_ready_d = 1'b1;
         S_RUN: begin
            cpu_nrst_d = 1'b1;
            done_d     = 1'b1;
         end
         S_ERROR: err_d = 1'b1;
         default: ;
      endcase
   end

   // Registered outputs, write pointer, word counter and hold timer
   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready      <= 1'b0;
         cpu_nrst     <= 1'b0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= START_ADDR;
         mem_wdata    <= '0;
         word_count   <= '0;
         ptr          <= START_ADDR;
         hold_cnt     <= '0;
      end else begin
         s_ready      <= s_ready_d;
         cpu_nrst     <= cpu_nrst_d;
         done         <= done_d;
         err_overflow <= err_d;
         mem_we       <= xfer_c;
         if (xfer_c) begin
            mem_addr   <= ptr;
            mem_wdata  <= s_data;
            ptr        <= ptr + 16'd2;
            word_count <= count_inc_c;
         end
         if (restart_c) begin
            ptr        <= START_ADDR;
            word_count <= '0;
         end
         if ((state != S_HOLD) && (next_state == S_HOLD)) hold_cnt <= HOLD_CNT;
         else if ((state == S_HOLD) && (hold_cnt != '0))  hold_cnt <= hold_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: dut_a uses defaults, dut_b uses
// START_ADDR=0x0100 and MAX_WORDS=4; both share the same stimulus.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_last;

   logic        a_s_ready, a_we, a_nrst, a_done, a_err;
   logic [15:0] a_addr, a_wdata, a_wc;
   logic        b_s_ready, b_we, b_nrst, b_done, b_err;
   logic [15:0] b_addr, b_wdata, b_wc;

   int n_checks = 0;
   int n_pass   = 0;

   program_loader dut_a (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(a_s_ready), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .mem_we(a_we), .cpu_nrst(a_nrst), .done(a_done), .err_overflow(a_err),
      .word_count(a_wc)
   );

   program_loader #(.START_ADDR(16'h0100), .MAX_WORDS(4), .HOLD_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(b_s_ready), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .mem_we(b_we), .cpu_nrst(b_nrst), .done(b_done), .err_overflow(b_err),
      .word_count(b_wc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic        bp_v [5];
   logic [15:0] bp_d [5];
   logic [15:0] exp_addr;

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      bp_v[0] = 1'b1; bp_v[1] = 1'b0; bp_v[2] = 1'b0; bp_v[3] = 1'b1; bp_v[4] = 1'b1;
      bp_d[0] = 16'hAAA1; bp_d[1] = 16'hDEAD; bp_d[2] = 16'hDEAD; bp_d[3] = 16'hAAA2; bp_d[4] = 16'hAAA3;

      // Reset state
      tick();
      rst = 1'b0;
      check("rst_s_ready", 32'(a_s_ready), 32'd0);
      check("rst_we",      32'(a_we),      32'd0);
      check("rst_addr",    32'(a_addr),    32'h0000);
      check("rst_wdata",   32'(a_wdata),   32'h0000);
      check("rst_nrst",    32'(a_nrst),    32'd0);
      check("rst_done",    32'(a_done),    32'd0);
      check("rst_err",     32'(a_err),     32'd0);
      check("rst_wc",      32'(a_wc),      32'd0);
      check("rst_b_addr",  32'(b_addr),    32'h0100);

      // Basic load: 3 words, continuous valid
      start = 1'b1; tick(); start = 1'b0;
      check("basic_ready", 32'(a_s_ready), 32'd1);
      s_valid = 1'b1; s_data = 16'h1111; tick();
      check("basic_we0",   32'(a_we),    32'd1);
      check("basic_addr0", 32'(a_addr),  32'h0000);
      check("basic_data0", 32'(a_wdata), 32'h1111);
      s_data = 16'h2222; tick();
      check("basic_we1",   32'(a_we),    32'd1);
      check("basic_addr1", 32'(a_addr),  32'h0002);
      check("basic_data1", 32'(a_wdata), 32'h2222);
      s_data = 16'h3333; s_last = 1'b1; tick();
      check("basic_we2",   32'(a_we),      32'd1);
      check("basic_addr2", 32'(a_addr),    32'h0004);
      check("basic_data2", 32'(a_wdata),   32'h3333);
      check("basic_wc",    32'(a_wc),      32'd3);
      check("basic_ready_hold", 32'(a_s_ready), 32'd0);
      s_valid = 1'b0; s_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("basic_hold_nrst", 32'(a_nrst), 32'd0);
         check("basic_hold_we",   32'(a_we),   32'd0);
      end
      tick();
      check("basic_run_nrst", 32'(a_nrst), 32'd1);
      check("basic_run_done", 32'(a_done), 32'd1);

      // Backpressure gaps on dut_b
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      exp_addr = 16'h0100;
      for (int i = 0; i < 5; i++) begin
         s_valid = bp_v[i]; s_data = bp_d[i]; s_last = (i == 4);
         tick();
         check("bp_we", 32'(b_we), 32'(bp_v[i]));
         if (bp_v[i]) begin
            check("bp_addr", 32'(b_addr),  32'(exp_addr));
            check("bp_data", 32'(b_wdata), 32'(bp_d[i]));
            exp_addr = exp_addr + 16'd2;
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      check("bp_wc", 32'(b_wc), 32'd3);

      // Overflow on dut_b (MAX_WORDS=4)
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 16'h0C00 + 16'(i); s_last = 1'b0;
         tick();
         check("ovf_we",   32'(b_we),    32'd1);
         check("ovf_addr", 32'(b_addr),  32'h0100 + 32'(2 * i));
         check("ovf_data", 32'(b_wdata), 32'h0C00 + 32'(i));
      end
      check("ovf_ready", 32'(b_s_ready), 32'd0);
      check("ovf_err",   32'(b_err),     32'd1);
      check("ovf_nrst",  32'(b_nrst),    32'd0);
      check("ovf_wc",    32'(b_wc),      32'd4);
      s_data = 16'h0C04; tick();
      check("ovf_5th_we", 32'(b_we), 32'd0);
      check("ovf_5th_wc", 32'(b_wc), 32'd4);
      s_valid = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      check("ovf_sticky",      32'(b_err),     32'd1);
      check("ovf_start_ready", 32'(b_s_ready), 32'd0);
      check("ovf_done",        32'(b_done),    32'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      check("ovf_rst_err",  32'(b_err),  32'd0);
      check("ovf_rst_addr", 32'(b_addr), 32'h0100);

      // Exact capacity: s_last on the 4th word
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 16'h0E00 + 16'(i); s_last = (i == 3);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0;
      check("cap_we",    32'(b_we),      32'd1);
      check("cap_addr",  32'(b_addr),    32'h0106);
      check("cap_ready", 32'(b_s_ready), 32'd0);
      check("cap_err",   32'(b_err),     32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("cap_hold_nrst", 32'(b_nrst), 32'd0);
      end
      tick();
      check("cap_run_nrst", 32'(b_nrst), 32'd1);
      check("cap_run_done", 32'(b_done), 32'd1);
      check("cap_run_err",  32'(b_err),  32'd0);
      check("cap_run_we",   32'(b_we),   32'd0);
      check("a_run_nrst",   32'(a_nrst), 32'd1);

      // Reload from RUN on dut_a
      start = 1'b1; tick(); start = 1'b0;
      check("rl_nrst",  32'(a_nrst),    32'd0);
      check("rl_done",  32'(a_done),    32'd0);
      check("rl_wc",    32'(a_wc),      32'd0);
      check("rl_ready", 32'(a_s_ready), 32'd1);
      s_valid = 1'b1; s_data = 16'hBEEF; s_last = 1'b1; tick();
      s_valid = 1'b0; s_last = 1'b0;
      check("rl_we",   32'(a_we),    32'd1);
      check("rl_addr", 32'(a_addr),  32'h0000);
      check("rl_data", 32'(a_wdata), 32'hBEEF);
      check("rl_wc1",  32'(a_wc),    32'd1);
      repeat (4) tick();
      check("rl_hold_nrst", 32'(a_nrst), 32'd0);
      tick();
      check("rl_run_nrst", 32'(a_nrst), 32'd1);
      check("rl_run_done", 32'(a_done), 32'd1);

      // Reset mid-load on dut_a
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      s_valid = 1'b1; s_data = 16'h7001; tick();
      s_data = 16'h7002; tick();
      s_data = 16'h7003; rst = 1'b1; tick(); rst = 1'b0;
      check("mid_ready", 32'(a_s_ready), 32'd0);
      check("mid_we",    32'(a_we),      32'd0);
      check("mid_addr",  32'(a_addr),    32'h0000);
      check("mid_wdata", 32'(a_wdata),   32'h0000);
      check("mid_nrst",  32'(a_nrst),    32'd0);
      check("mid_wc",    32'(a_wc),      32'd0);
      tick();
      check("mid_idle_we",    32'(a_we),      32'd0);
      check("mid_idle_ready", 32'(a_s_ready), 32'd0);
      // start together with valid in IDLE: word not taken
      s_data = 16'h5555; s_last = 1'b1; start = 1'b1; tick(); start = 1'b0;
      check("idle_sv_we",    32'(a_we),      32'd0);
      check("idle_sv_wc",    32'(a_wc),      32'd0);
      check("idle_sv_ready", 32'(a_s_ready), 32'd1);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      check("relo_we",   32'(a_we),    32'd1);
      check("relo_addr", 32'(a_addr),  32'h0000);
      check("relo_data", 32'(a_wdata), 32'h5555);
      check("relo_wc",   32'(a_wc),    32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
